// File: rtl/bram_arbiter.sv
// Two-port round-robin front end for a single-port, read-first BRAM.
// Byte-strobed partial writes are done as read (accept cycle) then merged write (MERGE).
module bram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      m0_req_valid,
  output logic                      m0_req_ready,
  input  logic [ADDR_WIDTH-1:0]     m0_req_addr,
  input  logic                      m0_req_we,
  input  logic [DATA_WIDTH/8-1:0]   m0_req_wstrb,
  input  logic [DATA_WIDTH-1:0]     m0_req_wdata,
  output logic                      m0_rsp_valid,
  output logic [DATA_WIDTH-1:0]     m0_rsp_rdata,

  input  logic                      m1_req_valid,
  output logic                      m1_req_ready,
  input  logic [ADDR_WIDTH-1:0]     m1_req_addr,
  input  logic                      m1_req_we,
  input  logic [DATA_WIDTH/8-1:0]   m1_req_wstrb,
  input  logic [DATA_WIDTH-1:0]     m1_req_wdata,
  output logic                      m1_rsp_valid,
  output logic [DATA_WIDTH-1:0]     m1_rsp_rdata,

  output logic                      bram_we,
  output logic [ADDR_WIDTH-1:0]     bram_addr,
  output logic [DATA_WIDTH-1:0]     bram_din,
  input  logic [DATA_WIDTH-1:0]     bram_dout
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_MERGE = 2'd2
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (strb[i]) begin
        res[i*8 +: 8] = new_word[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_word[i*8 +: 8];
      end
    end
    return res;
  endfunction

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [NB-1:0]           wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0]   m1_rdata_q, m1_rdata_d;

  logic                    grant_s;
  logic                    accept_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic                    sel_we_s;
  logic [NB-1:0]           sel_wstrb_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;
  logic                    full_s;
  logic                    partial_s;
  logic                    ready0_s, ready1_s;
  logic                    we_s;
  logic [ADDR_WIDTH-1:0]   baddr_s;
  logic [DATA_WIDTH-1:0]   din_s;
  logic                    rsp0_s, rsp1_s;

  // Round-robin pick: on a tie the requester not granted last time wins.
  always_comb begin
    grant_s = 1'b0;
    if (m0_req_valid && m1_req_valid) begin
      grant_s = ~last_grant_q;
    end else if (m1_req_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s    = (state_q != ST_MERGE) && (m0_req_valid || m1_req_valid);
  assign sel_addr_s  = grant_s ? m1_req_addr  : m0_req_addr;
  assign sel_we_s    = grant_s ? m1_req_we    : m0_req_we;
  assign sel_wstrb_s = grant_s ? m1_req_wstrb : m0_req_wstrb;
  assign sel_wdata_s = grant_s ? m1_req_wdata : m0_req_wdata;
  assign full_s      = sel_we_s && (sel_wstrb_s == {NB{1'b1}});
  assign partial_s   = sel_we_s && (sel_wstrb_s != {NB{1'b0}}) && !full_s;

  // Next state, BRAM port drive and request capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    ready0_s     = 1'b0;
    ready1_s     = 1'b0;
    we_s         = 1'b0;
    baddr_s      = {ADDR_WIDTH{1'b0}};
    din_s        = {DATA_WIDTH{1'b0}};
    case (state_q)
      ST_MERGE: begin
        we_s    = 1'b1;
        baddr_s = addr_q;
        din_s   = merge_bytes(bram_dout, wdata_q, wstrb_q);
        state_d = ST_RESP;
      end
      ST_IDLE, ST_RESP: begin
        if (accept_s) begin
          ready0_s     = ~grant_s;
          ready1_s     = grant_s;
          last_grant_d = grant_s;
          grant_d      = grant_s;
          addr_d       = sel_addr_s;
          wstrb_d      = sel_wstrb_s;
          wdata_d      = sel_wdata_s;
          baddr_s      = sel_addr_s;
          if (full_s) begin
            we_s    = 1'b1;
            din_s   = sel_wdata_s;
            state_d = ST_RESP;
          end else if (partial_s) begin
            we_s    = 1'b0;
            state_d = ST_MERGE;
          end else begin
            we_s    = 1'b0;
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The BRAM's registered dout is the response word; the idle requester keeps its last one.
  assign rsp0_s     = (state_q == ST_RESP) && !grant_q;
  assign rsp1_s     = (state_q == ST_RESP) && grant_q;
  assign m0_rdata_d = rsp0_s ? bram_dout : m0_rdata_q;
  assign m1_rdata_d = rsp1_s ? bram_dout : m1_rdata_q;

  // Control and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      wstrb_q      <= {NB{1'b0}};
      wdata_q      <= {DATA_WIDTH{1'b0}};
      m0_rdata_q   <= {DATA_WIDTH{1'b0}};
      m1_rdata_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // Gating with rst_n keeps the BRAM quiet even in the cycle reset lands mid-MERGE.
  assign m0_req_ready = rst_n & ready0_s;
  assign m1_req_ready = rst_n & ready1_s;
  assign bram_we      = rst_n & we_s;
  assign bram_addr    = rst_n ? baddr_s : {ADDR_WIDTH{1'b0}};
  assign bram_din     = rst_n ? din_s   : {DATA_WIDTH{1'b0}};
  assign m0_rsp_valid = rsp0_s;
  assign m1_rsp_valid = rsp1_s;
  assign m0_rsp_rdata = m0_rdata_d;
  assign m1_rsp_rdata = m1_rdata_d;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: read-first BRAM model, expected-response queues per requester,
// and one task per scenario.
module tb_bram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
  logic [9:0]  m0_req_addr;
  logic [3:0]  m0_req_wstrb;
  logic [31:0] m0_req_wdata, m0_rsp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
  logic [9:0]  m1_req_addr;
  logic [3:0]  m1_req_wstrb;
  logic [31:0] m1_req_wdata, m1_rsp_rdata;
  logic        bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_din, bram_dout;

  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem     [0:1023];
  logic [31:0] exp_mem [0:1023];

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int          total;
  int          bad;
  int          cyc;
  logic        mon_en;
  logic [31:0] hold0, hold1;

  bram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_we(m0_req_we), .m0_req_wstrb(m0_req_wstrb), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_we(m1_req_we), .m1_req_wstrb(m1_req_wstrb), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-first single-port BRAM with a back-door preload port.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else begin
      bram_dout <= mem[bram_addr];
      if (bram_we) mem[bram_addr] <= bram_din;
    end
  end

  // Response monitor: each requester either has a response due this cycle or must stay quiet.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold0 = 32'h0;
      hold1 = 32'h0;
    end
    if (mon_en) begin
      total++;
      if (q0.size() > 0 && q0[0].due == cyc) begin
        if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== q0[0].data) begin
          bad++;
          $display("FAIL m0_rsp cyc=%0d got valid=%b data=%h want valid=1 data=%h",
                   cyc, m0_rsp_valid, m0_rsp_rdata, q0[0].data);
        end
        hold0 = q0[0].data;
        void'(q0.pop_front());
      end else if (m0_rsp_valid !== 1'b0 || m0_rsp_rdata !== hold0) begin
        bad++;
        $display("FAIL m0_quiet cyc=%0d got valid=%b data=%h want valid=0 data=%h",
                 cyc, m0_rsp_valid, m0_rsp_rdata, hold0);
      end
      total++;
      if (q1.size() > 0 && q1[0].due == cyc) begin
        if (m1_rsp_valid !== 1'b1 || m1_rsp_rdata !== q1[0].data) begin
          bad++;
          $display("FAIL m1_rsp cyc=%0d got valid=%b data=%h want valid=1 data=%h",
                   cyc, m1_rsp_valid, m1_rsp_rdata, q1[0].data);
        end
        hold1 = q1[0].data;
        void'(q1.pop_front());
      end else if (m1_rsp_valid !== 1'b0 || m1_rsp_rdata !== hold1) begin
        bad++;
        $display("FAIL m1_quiet cyc=%0d got valid=%b data=%h want valid=0 data=%h",
                 cyc, m1_rsp_valid, m1_rsp_rdata, hold1);
      end
    end
  end

  // Model of an accepted request: response carries the pre-write word.
  task automatic push(input int who, input logic [9:0] a, input logic we,
                      input logic [3:0] st, input logic [31:0] wd, input int lat);
    exp_t        e;
    logic [31:0] nw;
    nw = exp_mem[a];
    if (we) begin
      for (int i = 0; i < 4; i++) if (st[i]) nw[i*8 +: 8] = wd[i*8 +: 8];
    end
    e.data = exp_mem[a];
    e.due  = cyc + lat;
    exp_mem[a] = nw;
    if (who == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    exp_mem[a] = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic clear_inputs();
    m0_req_valid = 1'b0; m0_req_addr = 10'd0; m0_req_we = 1'b0;
    m0_req_wstrb = 4'h0; m0_req_wdata = 32'h0;
    m1_req_valid = 1'b0; m1_req_addr = 10'd0; m1_req_we = 1'b0;
    m1_req_wstrb = 4'h0; m1_req_wdata = 32'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      clear_inputs();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mon_en = 1'b0;
    m0_req_valid = 1'b1; m0_req_addr = 10'd5; m0_req_we = 1'b0;
    m0_req_wstrb = 4'h0; m0_req_wdata = 32'h0;
    m1_req_valid = 1'b1; m1_req_addr = 10'd7; m1_req_we = 1'b1;
    m1_req_wstrb = 4'hF; m1_req_wdata = 32'hFFFF_FFFF;
    preload(10'd5, 32'hDEAD_BEEF);
    preload(10'd7, 32'h1122_3344);
    preload(10'd2, 32'hCAFE_F00D);
    preload(10'd3, 32'hA5A5_0003);
    for (int a = 1; a <= 12; a++) begin
      if (a != 2 && a != 3 && a != 5 && a != 7) preload(10'(a), 32'h1000_0000 + 32'(a));
    end
    #1;
    total++;
    if ({m0_req_ready, m1_req_ready, bram_we, bram_addr, bram_din} !== 45'h0) begin
      bad++;
      $display("FAIL reset_req_side got rdy0=%b rdy1=%b we=%b addr=%h din=%h want all 0",
               m0_req_ready, m1_req_ready, bram_we, bram_addr, bram_din);
    end
    total++;
    if ({m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, m1_rsp_rdata} !== 66'h0) begin
      bad++;
      $display("FAIL reset_rsp_side got v0=%b v1=%b d0=%h d1=%h want all 0",
               m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, m1_rsp_rdata);
    end
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_single_read();
    @(posedge clk); #1;
    m0_req_valid = 1'b1; m0_req_addr = 10'd5; m0_req_we = 1'b0;
    #2;
    total++;
    if ({m0_req_ready, m1_req_ready, bram_we, bram_addr} !== {1'b1, 1'b0, 1'b0, 10'd5}) begin
      bad++;
      $display("FAIL single_read_accept got rdy0=%b rdy1=%b we=%b addr=%0d want 1 0 0 5",
               m0_req_ready, m1_req_ready, bram_we, bram_addr);
    end
    push(0, 10'd5, 1'b0, 4'h0, 32'h0, 1);
    idle(3);
  endtask

  task automatic test_round_robin();
    int n0;
    int n1;
    int g;
    logic [9:0] ea;
    n0 = 0;
    n1 = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      m0_req_valid = (n0 < 4); m0_req_addr = 10'(1 + n0); m0_req_we = 1'b0;
      m1_req_valid = (n1 < 4); m1_req_addr = 10'(9 + n1); m1_req_we = 1'b0;
      #2;
      g  = i % 2;
      ea = (g == 0) ? 10'(1 + n0) : 10'(9 + n1);
      total++;
      if ({m0_req_ready, m1_req_ready} !== ((g == 0) ? 2'b10 : 2'b01) || bram_addr !== ea) begin
        bad++;
        $display("FAIL rr_grant step=%0d got rdy0=%b rdy1=%b addr=%0d want grant m%0d addr=%0d",
                 i, m0_req_ready, m1_req_ready, bram_addr, g, ea);
      end
      push(g, ea, 1'b0, 4'h0, 32'h0, 1);
      if (g == 0) n0++;
      else n1++;
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    m1_req_valid = 1'b1; m1_req_addr = 10'd3; m1_req_we = 1'b1;
    m1_req_wstrb = 4'hF; m1_req_wdata = 32'h1234_5678;
    #2;
    total++;
    if ({m0_req_ready, m1_req_ready, bram_we, bram_din} !== {1'b0, 1'b1, 1'b1, 32'h1234_5678}) begin
      bad++;
      $display("FAIL full_write got rdy0=%b rdy1=%b we=%b din=%h want 0 1 1 12345678",
               m0_req_ready, m1_req_ready, bram_we, bram_din);
    end
    push(1, 10'd3, 1'b1, 4'hF, 32'h1234_5678, 1);
    @(posedge clk); #1;
    clear_inputs();
    m0_req_valid = 1'b1; m0_req_addr = 10'd3;
    #2;
    total++;
    if ({m0_req_ready, bram_we, bram_addr} !== {1'b1, 1'b0, 10'd3}) begin
      bad++;
      $display("FAIL bypass_read got rdy0=%b we=%b addr=%0d want 1 0 3",
               m0_req_ready, bram_we, bram_addr);
    end
    push(0, 10'd3, 1'b0, 4'h0, 32'h0, 1);
    idle(3);
  endtask

  task automatic test_partial_write();
    @(posedge clk); #1;
    m0_req_valid = 1'b1; m0_req_addr = 10'd7; m0_req_we = 1'b0;
    m1_req_valid = 1'b1; m1_req_addr = 10'd7; m1_req_we = 1'b1;
    m1_req_wstrb = 4'b0010; m1_req_wdata = 32'h0000_AB00;
    #2;
    total++;
    if ({m0_req_ready, m1_req_ready, bram_we, bram_addr} !== {1'b0, 1'b1, 1'b0, 10'd7}) begin
      bad++;
      $display("FAIL partial_accept got rdy0=%b rdy1=%b we=%b addr=%0d want 0 1 0 7",
               m0_req_ready, m1_req_ready, bram_we, bram_addr);
    end
    push(1, 10'd7, 1'b1, 4'b0010, 32'h0000_AB00, 2);
    @(posedge clk); #1;
    m1_req_valid = 1'b0;
    #2;
    total++;
    if ({m0_req_ready, m1_req_ready, bram_we, bram_addr, bram_din}
        !== {1'b0, 1'b0, 1'b1, 10'd7, 32'h1122_AB44}) begin
      bad++;
      $display("FAIL merge_cycle got rdy0=%b rdy1=%b we=%b addr=%0d din=%h want 0 0 1 7 1122ab44",
               m0_req_ready, m1_req_ready, bram_we, bram_addr, bram_din);
    end
    @(posedge clk); #1;
    #2;
    total++;
    if ({m0_req_ready, bram_we, bram_addr} !== {1'b1, 1'b0, 10'd7}) begin
      bad++;
      $display("FAIL accept_in_resp got rdy0=%b we=%b addr=%0d want 1 0 7",
               m0_req_ready, bram_we, bram_addr);
    end
    push(0, 10'd7, 1'b0, 4'h0, 32'h0, 1);
    idle(3);
  endtask

  task automatic test_reset_in_merge();
    preload(10'd7, 32'h1122_3344);
    @(posedge clk); #1;
    m1_req_valid = 1'b1; m1_req_addr = 10'd7; m1_req_we = 1'b1;
    m1_req_wstrb = 4'b0010; m1_req_wdata = 32'h0000_AB00;
    #2;
    total++;
    if (m1_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL merge_rst_accept got rdy1=%b want 1", m1_req_ready);
    end
    @(posedge clk); #1;
    clear_inputs();
    m0_req_valid = 1'b1; m0_req_addr = 10'd7;
    rst_n = 1'b0;
    #1;
    total++;
    if ({m0_req_ready, m1_req_ready, bram_we, bram_addr, bram_din,
         m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, m1_rsp_rdata} !== 111'h0) begin
      bad++;
      $display("FAIL merge_rst_outputs got rdy=%b%b we=%b addr=%h din=%h v=%b%b d0=%h d1=%h want all 0",
               m0_req_ready, m1_req_ready, bram_we, bram_addr, bram_din,
               m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, m1_rsp_rdata);
    end
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    total++;
    if (mem[7] !== 32'h1122_3344) begin
      bad++;
      $display("FAIL merge_rst_mem got=%h want=11223344", mem[7]);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_zero_strobe();
    @(posedge clk); #1;
    m0_req_valid = 1'b1; m0_req_addr = 10'd2; m0_req_we = 1'b1;
    m0_req_wstrb = 4'h0; m0_req_wdata = 32'hFFFF_FFFF;
    #2;
    total++;
    if ({m0_req_ready, bram_we, bram_addr} !== {1'b1, 1'b0, 10'd2}) begin
      bad++;
      $display("FAIL zero_strb_accept got rdy0=%b we=%b addr=%0d want 1 0 2",
               m0_req_ready, bram_we, bram_addr);
    end
    push(0, 10'd2, 1'b1, 4'h0, 32'hFFFF_FFFF, 1);
    @(posedge clk); #1;
    m0_req_we = 1'b0; m0_req_wdata = 32'h0;
    #2;
    total++;
    if (m0_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_strb_reread got rdy0=%b want 1", m0_req_ready);
    end
    push(0, 10'd2, 1'b0, 4'h0, 32'h0, 1);
    idle(3);
    total++;
    if (mem[2] !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL zero_strb_mem got=%h want=cafef00d", mem[2]);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    cyc    = 0;
    mon_en = 1'b0;
    hold0  = 32'h0;
    hold1  = 32'h0;
    pre_we = 1'b0; pre_addr = 10'd0; pre_data = 32'h0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back();
    test_partial_write();
    test_reset_in_merge();
    test_zero_strobe();
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL pending_responses got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one single-port, synchronous-read BRAM between two requesters: m0 (instruction fetch) and m1 (load/store unit).
- Arbitrates round-robin, returns read data one cycle after acceptance, and implements byte-strobed writes as a read-modify-write sequence.
- Sits between the core front/back ends and the BRAM instance.
- The BRAM has read-first behaviour: on a write edge, dout returns the old word.

Parameters:
- ADDR_WIDTH, 10, word-address width; matches the BRAM.
- DATA_WIDTH, 32, data width; must be a multiple of 8. NB = DATA_WIDTH/8.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- m0_req_valid / m1_req_valid  in  1  request present
- m0_req_ready / m1_req_ready  out  1  request accepted this cycle (combinational)
- m0_req_addr / m1_req_addr  in  ADDR_WIDTH  word address
- m0_req_we / m1_req_we  in  1  write request
- m0_req_wstrb / m1_req_wstrb  in  NB  byte enables (bit i selects byte i)
- m0_req_wdata / m1_req_wdata  in  DATA_WIDTH  write data
- m0_rsp_valid / m1_rsp_valid  out  1  one-cycle response pulse; no backpressure
- m0_rsp_rdata / m1_rsp_rdata  out  DATA_WIDTH  read data / old word
- bram_we  out  1  to BRAM we
- bram_addr  out  ADDR_WIDTH  to BRAM addr
- bram_din  out  DATA_WIDTH  to BRAM din
- bram_dout  in  DATA_WIDTH  from BRAM dout

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- States: IDLE, RESP, MERGE.
- Registered state: state, last_grant, captured grant, addr, wstrb, wdata.
- Reset values:
  - state=IDLE, last_grant=1 (m0 wins the first tie).
  - All rsp_valid=0, rsp_rdata=0.
  - While rst_n=0: req_ready=0, bram_we=0, bram_addr=0, bram_din=0.
- Handshake: the requester holds valid and payload stable until ready=1. Transfer occurs on valid&&ready at the rising edge.
- Acceptance is allowed only in IDLE and RESP. In MERGE, both readies are 0.
- Arbitration:
  - A single valid requester is granted.
  - If both are valid, grant !last_grant.
  - last_grant is updated on every accept.
  - ready is asserted only to the granted requester.
- On accept (cycle N), the granted request drives bram_addr combinationally. Request classes:
  - Read (we=0), or we=1 with wstrb=0: bram_we=0. Next state RESP.
  - Full write (wstrb all ones): bram_we=1, bram_din=wdata. Next state RESP.
  - Partial write (any other wstrb): bram_we=0 (read old word). Capture the request. Next state MERGE.
- MERGE (cycle N+1):
  - bram_addr=captured addr, bram_we=1.
  - bram_din byte i = wstrb[i] ? wdata byte i : bram_dout byte i.
  - Next state RESP.
- RESP:
  - Pulse rsp_valid for the captured grant only.
  - rsp_rdata=bram_dout; the other requester's rsp_rdata holds its last value.
  - Reads: fetched word. Writes: the pre-write word.
  - A new accept in the same cycle is allowed. Next state is set per the new request, or IDLE if none.
- Latency: read and full write respond at N+1; partial write at N+2. Sustained throughput is 1 request/cycle without partial writes.
- Bypass: a read accepted immediately after a write to the same address returns the new data.
- Address wrap: none; addresses are used directly.
- Reset mid-operation:
  - Asserting rst_n in any state forces IDLE immediately and bram_we=0.
  - In-flight responses are dropped; a MERGE write does not occur, so memory keeps the old word.

Test Plan:
- Reset, preload addr 5=0xDEADBEEF; m0 read addr 5 -> m0_req_ready=1 at cycle 0, m0_rsp_valid at cycle 1 with 0xDEADBEEF, m1_rsp_valid=0.
- Both requesters issue continuous reads (m0 addr 1..4, m1 addr 9..12) -> grants alternate m0,m1,m0,m1, one accept per cycle, responses 1 cycle after each accept to the correct requester.
- m1 full write addr 3=0x12345678, then m0 read addr 3 next cycle -> m1 rsp rdata=old word, m0 rsp rdata=0x12345678.
- addr 7=0x11223344; m1 write wstrb=0b0010 wdata=0x0000AB00 while m0 valid -> m0 stalled during MERGE, m1 rsp at N+2 with 0x11223344, readback 0x1122AB44.
- Repeat the partial write and assert rst_n=0 during MERGE -> bram_we=0, no rsp_valid, addr 7 still 0x11223344, all outputs at reset values.
- m0 write with wstrb=0 to addr 2=0xCAFEF00D -> treated as read, rsp rdata 0xCAFEF00D, memory unchanged.
